// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment rule used when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

  // Size must already be normalised (11 folded into SZ_WORD).
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges sub-word store data into the old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [1:0]            i_offset,
  output logic [DATA_WIDTH-1:0] o_load,
  output logic [DATA_WIDTH-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_bit_base;

  assign w_bit_base = {i_offset, 3'b000};
  assign w_byte     = i_word[w_bit_base +: 8];
  assign w_half     = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{(DATA_WIDTH-8){~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{(DATA_WIDTH-16){~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: o_merged[w_bit_base +: 8] = i_wdata[7:0];
      SZ_HALF: begin
        if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
        else             o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-addressed memory with a
// one-cycle registered read; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_misaligned_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_MemWrite_o,
  output logic                  mem_MemRead_o,
  input  logic [DATA_WIDTH-1:0] mem_data_read_i
);

  lsu_state_e            r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_mis;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [1:0]            w_size;
  logic                  w_mis;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_unused_addr;

  assign w_size        = (req_size_i == 2'b11) ? SZ_WORD : req_size_i;
  assign w_mis         = is_misaligned(w_size, req_addr_i[1:0]);
  // Address bits above the memory window are deliberately dropped (wrap-around).
  assign w_unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_word     (mem_data_read_i),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_offset   (r_addr[1:0]),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  assign req_ready_o       = (r_state == IDLE) && !rst;
  assign mem_MemRead_o     = (r_state == RD);
  assign mem_MemWrite_o    = (r_state == WR);
  assign mem_address_o     = r_addr[ADDR_WIDTH+1:2];
  assign mem_write_data_o  = r_wdata;
  assign resp_valid_o      = (r_state == RESP);
  assign resp_rdata_o      = resp_valid_o ? r_rdata : '0;
  assign resp_misaligned_o = resp_valid_o & r_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_mis      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_write    <= req_write_i;
            r_size     <= w_size;
            r_unsigned <= req_unsigned_i;
            r_mis      <= w_mis;
            r_addr     <= req_addr_i[ADDR_WIDTH+1:0];
            r_wdata    <= req_wdata_i;
            r_rdata    <= '0;
            if (w_mis)                                 r_state <= RESP;
            else if (req_write_i && w_size == SZ_WORD) r_state <= WR;
            else                                       r_state <= RD;
          end
        end
        RD:  r_state <= RDW;
        // Memory read data is valid here: either finish a load or build the RMW word.
        RDW: begin
          if (r_write) begin
            r_wdata <= w_merged;
            r_state <= WR;
          end else begin
            r_rdata <= w_load;
            r_state <= RESP;
          end
        end
        WR:      r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural memory, per-scenario
// tasks, and a queue of expected responses popped when the DUT responds.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_misaligned_o;
  logic [7:0]  mem_address_o;
  logic [31:0] mem_write_data_o;
  logic        mem_MemWrite_o;
  logic        mem_MemRead_o;
  logic [31:0] mem_data_read_i = '0;

  load_store_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_write_i       (req_write_i),
    .req_size_i        (req_size_i),
    .req_unsigned_i    (req_unsigned_i),
    .req_addr_i        (req_addr_i),
    .req_wdata_i       (req_wdata_i),
    .resp_valid_o      (resp_valid_o),
    .resp_rdata_o      (resp_rdata_o),
    .resp_misaligned_o (resp_misaligned_o),
    .mem_address_o     (mem_address_o),
    .mem_write_data_o  (mem_write_data_o),
    .mem_MemWrite_o    (mem_MemWrite_o),
    .mem_MemRead_o     (mem_MemRead_o),
    .mem_data_read_i   (mem_data_read_i)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_MemRead_o)  mem_data_read_i <= mem[mem_address_o];
    if (mem_MemWrite_o) mem[mem_address_o] <= mem_write_data_o;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Observations from the last transaction (cycle numbers relative to acceptance).
  int          rd_cyc, wr_cyc, resp_cyc;
  logic [7:0]  rd_addr, wr_addr;
  logic [31:0] wr_data, got_rdata;
  logic        got_mis, got_resp, ready_at_issue, ready_in_resp, both_strobes;

  task automatic run_txn(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
    rd_cyc = -1; wr_cyc = -1; resp_cyc = -1; got_resp = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; got_rdata = '0; got_mis = 1'b0;
    ready_in_resp = 1'b1; both_strobes = 1'b0;
    @(negedge clk);
    ready_at_issue = req_ready_o;
    req_write_i = w; req_size_i = sz; req_unsigned_i = u; req_addr_i = a; req_wdata_i = wd;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_MemRead_o && mem_MemWrite_o) both_strobes = 1'b1;
      if (mem_MemRead_o && rd_cyc < 0) begin rd_cyc = c; rd_addr = mem_address_o; end
      if (mem_MemWrite_o && wr_cyc < 0) begin
        wr_cyc = c; wr_addr = mem_address_o; wr_data = mem_write_data_o;
      end
      if (resp_valid_o) begin
        resp_cyc = c; got_rdata = resp_rdata_o; got_mis = resp_misaligned_o;
        ready_in_resp = req_ready_o; got_resp = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready_o); end
    checks++;
    if ({mem_MemRead_o, mem_MemWrite_o} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_MemRead_o, mem_MemWrite_o});
    end
    checks++;
    if ({resp_valid_o, resp_misaligned_o, resp_rdata_o} !== 34'd0) begin
      failures++; $display("FAIL reset_resp valid=%b mis=%b rdata=%h exp all 0",
                           resp_valid_o, resp_misaligned_o, resp_rdata_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_load_word();
    exp_t e;
    mem[8'h10] = 32'hDEADBEEF;
    exp_q.push_back('{rdata: 32'hDEADBEEF, mis: 1'b0});
    run_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++;
    if (ready_at_issue !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", ready_at_issue); end
    checks++;
    if (rd_cyc != 1 || rd_addr !== 8'h10) begin
      failures++; $display("FAIL lw_read cyc=%0d addr=%h exp cyc=1 addr=10", rd_cyc, rd_addr);
    end
    checks++;
    if (wr_cyc != -1) begin failures++; $display("FAIL lw_no_write wr_cyc=%0d exp=-1", wr_cyc); end
    checks++;
    if (!got_resp || resp_cyc != 3) begin
      failures++; $display("FAIL lw_resp_cycle got=%0d exp=3", resp_cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (got_rdata !== e.rdata || got_mis !== e.mis) begin
      failures++; $display("FAIL lw_data got=%h/%b exp=%h/%b", got_rdata, got_mis, e.rdata, e.mis);
    end
    checks++;
    if (ready_in_resp !== 1'b0) begin failures++; $display("FAIL lw_ready_in_resp got=%b exp=0", ready_in_resp); end
  endtask

  task automatic test_load_subword();
    exp_t e;
    logic [1:0]  sz[4]  = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad[4]  = '{32'h43, 32'h43, 32'h42, 32'h40};
    logic [31:0] ex[4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000000};
    mem[8'h10] = 32'h80FF0000;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{rdata: ex[i], mis: 1'b0});
      run_txn(1'b0, sz[i], un[i], ad[i], 32'h0);
      e = exp_q.pop_front();
      checks++;
      if (!got_resp || resp_cyc != 3 || got_rdata !== e.rdata || got_mis !== e.mis) begin
        failures++;
        $display("FAIL load_sub[%0d] cyc=%0d rdata=%h mis=%b exp cyc=3 rdata=%h mis=%b",
                 i, resp_cyc, got_rdata, got_mis, e.rdata, e.mis);
      end
    end
  endtask

  task automatic test_store_half();
    exp_t e;
    mem[8'h10] = 32'h11112222;
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0});
    run_txn(1'b1, 2'b01, 1'b0, 32'h42, 32'h1234ABCD);
    checks++;
    if (rd_cyc != 1) begin failures++; $display("FAIL sh_read_cycle got=%0d exp=1", rd_cyc); end
    checks++;
    if (wr_cyc != 3 || wr_addr !== 8'h10 || wr_data !== 32'hABCD2222) begin
      failures++; $display("FAIL sh_write cyc=%0d addr=%h data=%h exp cyc=3 addr=10 data=abcd2222",
                           wr_cyc, wr_addr, wr_data);
    end
    e = exp_q.pop_front();
    checks++;
    if (!got_resp || resp_cyc != 4 || got_rdata !== e.rdata || got_mis !== e.mis) begin
      failures++; $display("FAIL sh_resp cyc=%0d rdata=%h mis=%b exp cyc=4 rdata=0 mis=0",
                           resp_cyc, got_rdata, got_mis);
    end
    checks++;
    if (mem[8'h10] !== 32'hABCD2222) begin failures++; $display("FAIL sh_mem got=%h exp=abcd2222", mem[8'h10]); end
  endtask

  task automatic test_store_word();
    exp_t e;
    mem[8'h11] = 32'h0;
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0});
    run_txn(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFEF00D);
    checks++;
    if (rd_cyc != -1) begin failures++; $display("FAIL sw_no_read rd_cyc=%0d exp=-1", rd_cyc); end
    checks++;
    if (wr_cyc != 1 || wr_addr !== 8'h11 || wr_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL sw_write cyc=%0d addr=%h data=%h exp cyc=1 addr=11 data=cafef00d",
                           wr_cyc, wr_addr, wr_data);
    end
    e = exp_q.pop_front();
    checks++;
    if (!got_resp || resp_cyc != 2 || got_rdata !== e.rdata || got_mis !== e.mis) begin
      failures++; $display("FAIL sw_resp cyc=%0d rdata=%h mis=%b exp cyc=2 rdata=0 mis=0",
                           resp_cyc, got_rdata, got_mis);
    end
    checks++;
    if (mem[8'h11] !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_mem got=%h exp=cafef00d", mem[8'h11]); end
  endtask

  task automatic test_misaligned();
    exp_t e;
    logic        wr[3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz[3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad[3] = '{32'h42, 32'h41, 32'h43};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rdata: 32'h0, mis: 1'b1});
      run_txn(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
      e = exp_q.pop_front();
      checks++;
      if (rd_cyc != -1 || wr_cyc != -1) begin
        failures++; $display("FAIL mis_strobes[%0d] rd=%0d wr=%0d exp none", i, rd_cyc, wr_cyc);
      end
      checks++;
      if (!got_resp || resp_cyc != 1 || got_rdata !== e.rdata || got_mis !== e.mis) begin
        failures++; $display("FAIL mis_resp[%0d] cyc=%0d rdata=%h mis=%b exp cyc=1 rdata=0 mis=1",
                             i, resp_cyc, got_rdata, got_mis);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    mem[8'h10] = 32'h0BADF00D;
    exp_q.push_back('{rdata: 32'h0BADF00D, mis: 1'b0});
    run_txn(1'b0, 2'b10, 1'b0, 32'hFFFF_FC40, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (rd_addr !== 8'h10 || got_rdata !== e.rdata) begin
      failures++; $display("FAIL wrap addr=%h rdata=%h exp addr=10 rdata=%h", rd_addr, got_rdata, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mem[8'h10] = 32'h11112222;
    exp_q.push_back('{rdata: 32'h0, mis: 1'b0});
    run_txn(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A);
    e = exp_q.pop_front();
    checks++;
    if (wr_data !== 32'h11115A22 || got_rdata !== e.rdata) begin
      failures++; $display("FAIL sb_merge data=%h rdata=%h exp data=11115a22 rdata=0", wr_data, got_rdata);
    end
    exp_q.push_back('{rdata: 32'h0000005A, mis: 1'b0});
    run_txn(1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    checks++;
    if (ready_at_issue !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ready_at_issue); end
    e = exp_q.pop_front();
    checks++;
    if (!got_resp || got_rdata !== e.rdata || ready_in_resp !== 1'b0) begin
      failures++; $display("FAIL b2b_lbu rdata=%h ready_in_resp=%b exp rdata=%h ready=0",
                           got_rdata, ready_in_resp, e.rdata);
    end
  endtask

  task automatic test_reset_midop();
    logic seen;
    mem[8'h10] = 32'h11112222;
    @(negedge clk);
    req_write_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h41; req_wdata_i = 32'h000000EE; req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_MemWrite_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_state wr=%b resp=%b ready=%b exp 0/0/0",
                           mem_MemWrite_o, resp_valid_o, req_ready_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready_o); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_MemWrite_o || mem_MemRead_o || resp_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_activity got=%b exp=0", seen); end
    checks++;
    if (mem[8'h10] !== 32'h11112222) begin failures++; $display("FAIL rst_mid_mem got=%h exp=11112222", mem[8'h10]); end
  endtask

  logic both_any = 1'b0;
  always @(negedge clk) if (mem_MemRead_o && mem_MemWrite_o) both_any = 1'b1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_load_word();
    test_load_subword();
    test_store_half();
    test_store_word();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    checks++;
    if (both_any !== 1'b0) begin failures++; $display("FAIL strobe_exclusive got=%b exp=0", both_any); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, giving the memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the data word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit: core request valid.
REQ-006 SHALL have port req_ready_o, output, 1 bit: unit can accept a request.
REQ-007 SHALL have port req_write_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size_i, input, 2 bits: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 SHALL have port req_unsigned_i, input, 1 bit: zero-extend loads (LBU/LHU).
REQ-010 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata_i, input, DATA_WIDTH bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid_o, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata_o, output, DATA_WIDTH bits: extended load data; 0 for stores.
REQ-014 SHALL have port resp_misaligned_o, output, 1 bit: request rejected as misaligned; valid with resp_valid_o.
REQ-015 SHALL have port mem_address_o, output, ADDR_WIDTH bits: word address, req_addr_i[ADDR_WIDTH+1:2].
REQ-016 SHALL have port mem_write_data_o, output, DATA_WIDTH bits: full word to write.
REQ-017 SHALL have port mem_MemWrite_o, output, 1 bit: word write strobe.
REQ-018 SHALL have port mem_MemRead_o, output, 1 bit: read strobe.
REQ-019 SHALL have port mem_data_read_i, input, DATA_WIDTH bits: memory read data, registered, valid the cycle after mem_MemRead_o.

Function
REQ-020 SHALL implement the FSM states IDLE, RD, RDW, WR, RESP.
REQ-021 SHALL drive req_ready_o = (state==IDLE) && !rst; a request is accepted on an edge where req_valid_i && req_ready_o, and all request fields are captured then.
REQ-022 SHALL flag as misaligned a half access with addr[0]=1 or a word access with addr[1:0]!=0; from IDLE it goes directly to RESP with no memory strobes, resp_misaligned_o=1 and resp_rdata_o=0.
REQ-023 SHALL sequence a load as IDLE->RD->RDW->RESP; mem_MemRead_o=1 only in RD; in RDW it registers the extracted lane (byte addr[1:0], half addr[1]) sign- or zero-extended; resp_valid_o is high in the 3rd cycle after acceptance.
REQ-024 SHALL sequence a word store as IDLE->WR->RESP, with mem_MemWrite_o=1 only in WR and mem_write_data_o=req_wdata_i; resp_valid_o is high in the 2nd cycle after acceptance.
REQ-025 SHALL perform a sub-word store as read-modify-write IDLE->RD->RDW->WR->RESP; in RDW it registers the old word with the target byte/half replaced by the low bits of wdata; resp_valid_o is high in the 4th cycle after acceptance.
REQ-026 SHALL return RESP->IDLE unconditionally, with no request accepted in RESP; the minimum request spacing is therefore response cycle + 1.
REQ-027 SHALL never assert mem_MemRead_o and mem_MemWrite_o in the same cycle, and SHALL hold mem_address_o stable from RD/WR through RESP.
REQ-028 SHALL ignore address bits above ADDR_WIDTH+1, so addresses wrap modulo 2^(ADDR_WIDTH+2).
REQ-029 SHALL drive resp_rdata_o and resp_misaligned_o to 0 whenever resp_valid_o=0.

Reset
REQ-030 SHALL, on an edge with rst=1 in any state, enter IDLE, clear all registers, and drive both strobes 0, resp_valid_o=0, resp_rdata_o=0 and resp_misaligned_o=0.
REQ-031 SHALL, when reset occurs mid-operation, drop the request with no response; a write strobe is never issued after the reset edge.

Structure
REQ-032 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum in the shared package lsu_pkg.
REQ-033 SHALL place lane extract/extend and store merge in the combinational sub-module lsu_align, instantiated once.

Verification
REQ-034 SHALL cover: mem[0x10]=0xDEADBEEF, LW 0x40 -> MemRead in cycle 1 with address 0x10; resp_valid_o in cycle 3 with rdata 0xDEADBEEF.
REQ-035 SHALL cover: mem[0x10]=0x80FF0000, LB 0x43 -> 0xFFFFFF80; LBU 0x43 -> 0x00000080; LH 0x42 -> 0xFFFF80FF.
REQ-036 SHALL cover: mem[0x10]=0x11112222, SH 0x42 wdata 0x1234ABCD -> WR cycle 3 writes 0xABCD2222 to 0x10; resp_valid_o in cycle 4.
REQ-037 SHALL cover: SW 0x44 wdata 0xCAFEF00D -> no MemRead; MemWrite in cycle 1 at address 0x11; resp_valid_o in cycle 2.
REQ-038 SHALL cover: LW 0x42 -> no strobes; resp_valid_o in cycle 1 with misaligned=1 and rdata=0.
REQ-039 SHALL cover: rst in RDW of SB 0x41 -> no MemWrite ever; IDLE next cycle; req_ready_o=1 once rst=0.
